// File: rtl/adder_pkg.sv
// Shared definitions for the sequential multi-word adder.
//  - State encoding of the controller FSM.
//  - Default slice width and slice count.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DWL_DEF    = 4;
  localparam int NWORDS_DEF = 4;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Handshake bundle of the sequential multi-word adder.
//  Operand side : in_valid, in_ready, a_in, b_in
//  Result side  : out_valid, out_ready, sum, cout
//  slave  modport = adder view, master modport = producer/consumer view.
interface multiword_add_seq_if
  import adder_pkg::*;
#(
  parameter int DWL    = DWL_DEF,
  parameter int NWORDS = NWORDS_DEF
);

  localparam int W = DWL * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/multiword_add_seq_cla.sv
// Carry-lookahead slice adder (no carry-in).
//  a, b : DWL-bit addends
//  s    : DWL+1-bit result, s[DWL] is the carry out
//  cout : carry out (same value as s[DWL])
module CarryLookaheadAdder #(
  parameter int DWL = 4
) (
  input  logic [DWL-1:0] a,
  input  logic [DWL-1:0] b,
  output logic [DWL:0]   s,
  output logic           cout
);

  logic [DWL-1:0] g_s;
  logic [DWL-1:0] p_s;
  logic [DWL:0]   c_s;
  logic           run_p_s;

  // Flat lookahead: carry i+1 is g[j] AND every propagate between j+1 and i, ORed over j.
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    c_s     = '0;
    run_p_s = 1'b1;
    for (int i = 0; i < DWL; i++) begin
      c_s[i+1] = g_s[i];
      run_p_s  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        run_p_s  = run_p_s & p_s[j+1];
        c_s[i+1] = c_s[i+1] | (g_s[j] & run_p_s);
      end
    end
  end

  assign s    = {c_s[DWL], p_s ^ c_s[DWL-1:0]};
  assign cout = c_s[DWL];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one DWL-bit CLA slice per cycle, LSB slice first.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of multiword_add_seq_if (operand and result handshakes)
// Operands accepted at edge E give out_valid after edge E+NWORDS; the result is
// held stable until out_ready, and no operand is accepted during DONE.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int DWL    = DWL_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_add_seq_if.slave   bus
);

  localparam int W    = DWL * NWORDS;
  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;
  logic [W-1:0]    sum_r;
  logic            cout_r;
  logic            out_valid_r;
  logic            in_ready_s;
  logic            accept_s;
  logic            step_s;
  logic            last_s;
  logic [DWL:0]    cla_sum_s;
  logic [DWL:0]    slice_total_s;
  logic            cla_cout_unused;

  CarryLookaheadAdder #(.DWL(DWL)) u_cla (
    .a    (a_sh_r[DWL-1:0]),
    .b    (b_sh_r[DWL-1:0]),
    .s    (cla_sum_s),
    .cout (cla_cout_unused)
  );

  // Add the registered inter-slice carry; cannot overflow DWL+1 bits.
  always_comb begin
    slice_total_s = cla_sum_s + {{DWL{1'b0}}, carry_r};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) state_nxt_s = ST_RUN;
        else              state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (bus.out_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output / control decode from the current state.
  always_comb begin
    in_ready_s = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_RUN:  step_s     = 1'b1;
      ST_DONE: in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_ready_s & bus.in_valid;
    last_s   = step_s & (idx_r == LAST_IDX);
  end

  // Datapath: operand capture, slice write-back, result handover.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= bus.a_in;
      b_sh_r  <= bus.b_in;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
    end else if (step_s) begin
      sum_r[int'(idx_r)*DWL +: DWL] <= slice_total_s[DWL-1:0];
      carry_r <= slice_total_s[DWL];
      a_sh_r  <= a_sh_r >> DWL;
      b_sh_r  <= b_sh_r >> DWL;
      idx_r   <= idx_r + IDXW'(1);
      if (last_s) begin
        cout_r      <= slice_total_s[DWL];
        out_valid_r <= 1'b1;
      end
    end else if ((state_r == ST_DONE) && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (DWL=4, NWORDS=4).
module tb_multiword_add_seq;

  localparam int DWL    = 4;
  localparam int NWORDS = 4;
  localparam int W      = DWL * NWORDS;

  logic clk;
  logic rst;

  multiword_add_seq_if #(.DWL(DWL), .NWORDS(NWORDS)) bus ();

  multiword_add_seq #(.DWL(DWL), .NWORDS(NWORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle -> NWORDS cycles of work -> result held until taken.
  bit           m_live  = 1'b0;
  bit           m_idle  = 1'b1;
  int           m_cnt   = 0;
  bit           m_valid = 1'b0;
  bit           m_known = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic [W:0]   m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_idle = 1'b1; m_cnt = 0; m_valid = 1'b0;
      m_known = 1'b1; m_sum = '0; m_cout = 1'b0;
    end else if (m_live) begin
      if (m_idle) begin
        if (bus.in_valid) begin
          m_res   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
          m_idle  = 1'b0;
          m_cnt   = NWORDS;
          m_known = 1'b0;
        end
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_known = 1'b1;
          m_sum   = m_res[W-1:0];
          m_cout  = m_res[W];
        end
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_idle));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_known) begin
        chk("sum", 32'(bus.sum), 32'(m_sum));
        chk("cout", 32'(bus.cout), 32'(m_cout));
      end
    end
  end

  // Present operands once in_ready is seen; returns at the negedge after the accept edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL launch_timeout: in_ready never rose");
    end
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result and compare against hand-computed literals.
  task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(lat), 32'(NWORDS));
    chk({nm, "_sum"}, 32'(bus.sum), 32'(es));
    chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({nm, "_model_sum"}, 32'(m_sum), 32'(es));
    chk({nm, "_model_cout"}, 32'(m_cout), 32'(ec));
  endtask

  task automatic drain();
    int n = 0;
    while (bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL drain_timeout: out_valid stuck");
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sum", 32'(bus.sum), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);

    // 1..3: basic sums and full carry ripple
    launch(16'h0000, 16'h0000); wait_result("t1", 16'h0000, 1'b0); drain();
    launch(16'hFFFF, 16'h0001); wait_result("t2", 16'h0000, 1'b1); drain();
    launch(16'hFFFF, 16'hFFFF); wait_result("t3a", 16'hFFFE, 1'b1); drain();
    launch(16'h1234, 16'h4321); wait_result("t3b", 16'h5555, 1'b0); drain();

    // 4: back-pressure with in_valid held high through DONE
    bus.out_ready = 1'b0;
    launch(16'hA5A5, 16'h5A5A);
    bus.in_valid = 1'b1;
    bus.a_in     = 16'h0001;
    bus.b_in     = 16'h0002;
    wait_result("t4a", 16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_sum", 32'(bus.sum), 32'h0000_FFFF);
      chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_handover_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_handover_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t4_handover_sum", 32'(bus.sum), 32'h0000_FFFF);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_recapture_in_ready", 32'(bus.in_ready), 32'd0);
    wait_result("t4b", 16'h0003, 1'b0); drain();

    // 5: reset during the second slice
    launch(16'h1357, 16'h2468);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_sum", 32'(bus.sum), 32'd0);
    chk("t5_cout", 32'(bus.cout), 32'd0);
    launch(16'h8000, 16'h8000); wait_result("t5b", 16'h0000, 1'b1); drain();

    // 6: new operands offered during RUN must be ignored
    launch(16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'(i % 2 == 0);
      bus.a_in     = 16'($urandom);
      bus.b_in     = 16'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    begin
      int lat = 3;
      while (!bus.out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("t6_latency", 32'(lat), 32'(NWORDS));
    end
    chk("t6_sum", 32'(bus.sum), 32'h0000_3333);
    chk("t6_cout", 32'(bus.cout), 32'd0);
    drain();

    // Random traffic, checked each cycle by the model
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a_in      = 16'($urandom);
      bus.b_in      = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (NWORDS + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
